// File: rtl/pool_max2x2.sv
// Streaming 2x2, stride-2 max-pooling unit.
// Takes activation pixels in row-major order and emits one pooled value per
// 2x2 window with a sequential pooled address and an end-of-frame flag.
// Optional build macro: POOL_SIGNED_EN makes every max comparison signed
// (two's-complement pixels); when it is undefined, comparisons are unsigned.

// Two-input max. Ties may return either operand because the values are equal.
module pool_max2x2_cmp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

`ifdef POOL_SIGNED_EN
    // signed magnitude select
    always_comb y = ($signed(a) >= $signed(b)) ? a : b;
`else
    // unsigned magnitude select
    always_comb y = (a >= b) ? a : b;
`endif

endmodule

module pool_max2x2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_last_i,
    input  logic              act_valid_i,
    input  logic [DATA_W-1:0] act_result_i,
    input  logic [ADDR_W-1:0] act_result_address_i,
    output logic [DATA_W-1:0] pool_result_o,
    output logic [ADDR_W-1:0] pool_result_address_o,
    output logic              pool_last_o,
    output logic              pool_valid_o
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_N = IMG_W / 2;
    localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pool_out_t;

    logic [CW-1:0]                 col_q;
    logic [RW-1:0]                 row_q;
    logic [ADDR_W-1:0]             out_cnt_q;
    logic [DATA_W-1:0]             pair_q;
    logic [LB_N-1:0][DATA_W-1:0]   line_buf_q;
    pool_out_t                     out_q;

    logic [LBW-1:0]    lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] h_max;
    logic [DATA_W-1:0] win_max;
    logic              col_odd;
    logic              row_odd;
    logic              col_end;
    logic              row_end;
    logic              win_done;
    logic              unused_src_addr;

    // Source address is carried for debug upstream only; position comes from
    // the internal counters.
    assign unused_src_addr = ^act_result_address_i;

    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign col_end  = (col_q == CW'(IMG_W - 1));
    assign row_end  = (row_q == RW'(IMG_H - 1));
    assign win_done = act_valid_i && col_odd && row_odd;
    assign lb_idx   = LBW'(col_q >> 1);

    // line buffer read port for the current column pair
    always_comb begin
        lb_rd = '0;
        for (int i = 0; i < LB_N; i++)
            if (lb_idx == LBW'(i)) lb_rd = line_buf_q[i];
    end

    // horizontal max of the latched even pixel and the current odd pixel
    pool_max2x2_cmp #(.DATA_W(DATA_W)) u_cmp_h (
        .a (pair_q),
        .b (act_result_i),
        .y (h_max)
    );

    // vertical max against the row above, stored on the even row
    pool_max2x2_cmp #(.DATA_W(DATA_W)) u_cmp_v (
        .a (h_max),
        .b (lb_rd),
        .y (win_max)
    );

    // column/row position and pooled output index; act_last_i restarts the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
        end else if (act_last_i) begin
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
        end else if (act_valid_i) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            if (win_done)
                out_cnt_q <= (row_end && col_end) ? '0 : out_cnt_q + 1'b1;
        end
    end

    // pair register on even columns, line buffer write on even-row odd columns;
    // the line buffer survives act_last_i since the next even row overwrites it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_q     <= '0;
            line_buf_q <= '0;
        end else if (act_valid_i) begin
            if (!col_odd)
                pair_q <= act_result_i;
            else if (!row_odd)
                line_buf_q[lb_idx] <= h_max;
        end
    end

    // registered output: single-cycle valid/last, data and address hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q.valid <= win_done;
            out_q.last  <= win_done && ((row_end && col_end) || act_last_i);
            if (win_done) begin
                out_q.data <= win_max;
                out_q.addr <= out_cnt_q;
            end
        end
    end

    assign pool_valid_o          = out_q.valid;
    assign pool_last_o           = out_q.last;
    assign pool_result_o         = out_q.data;
    assign pool_result_address_o = out_q.addr;

endmodule

// File: tb/tb_pool_max2x2.sv
// Directed bench for pool_max2x2 (4x4 frame, 8-bit data, 10-bit address).
// Expected values are hand-computed; the signed-window expectations follow
// POOL_SIGNED_EN.
module tb_pool_max2x2;

    logic       clk;
    logic       rst;
    logic       act_last_i;
    logic       act_valid_i;
    logic [7:0] act_result_i;
    logic [9:0] act_result_address_i;
    logic [7:0] pool_result_o;
    logic [9:0] pool_result_address_o;
    logic       pool_last_o;
    logic       pool_valid_o;

    int total  = 0;
    int passed = 0;
    logic [7:0] hold_d = '0;
    logic [9:0] hold_a = '0;

    pool_max2x2 #(.DATA_W(8), .ADDR_W(10), .IMG_W(4), .IMG_H(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .act_last_i            (act_last_i),
        .act_valid_i           (act_valid_i),
        .act_result_i          (act_result_i),
        .act_result_address_i  (act_result_address_i),
        .pool_result_o         (pool_result_o),
        .pool_result_address_o (pool_result_address_o),
        .pool_last_o           (pool_last_o),
        .pool_valid_o          (pool_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, sample #1 after the edge that registers the result.
    task automatic step(input bit v, input logic [7:0] d, input bit l,
                        input bit ev, input logic [7:0] ed, input logic [9:0] ea,
                        input bit el);
        act_valid_i  = v;
        act_result_i = d;
        act_last_i   = l;
        @(posedge clk);
        #1;
        if (v) act_result_address_i = act_result_address_i + 1'b1;
        chk("valid", {31'd0, pool_valid_o}, {31'd0, ev});
        if (ev) begin
            chk("data", {24'd0, pool_result_o}, {24'd0, ed});
            chk("addr", {22'd0, pool_result_address_o}, {22'd0, ea});
            chk("last", {31'd0, pool_last_o}, {31'd0, el});
            hold_d = ed;
            hold_a = ea;
        end else begin
            chk("hold_data", {24'd0, pool_result_o}, {24'd0, hold_d});
            chk("hold_addr", {22'd0, pool_result_address_o}, {22'd0, hold_a});
            chk("last_idle", {31'd0, pool_last_o}, 32'd0);
        end
        act_valid_i = 1'b0;
        act_last_i  = 1'b0;
    endtask

    // Full 4x4 frame; windows complete on pixels #6, #8, #14, #16.
    task automatic frame16(input logic [7:0] px [16], input logic [7:0] ex [4],
                           input bit last16, input bit bub);
        int k;
        bit w;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            w = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            step(1'b1, px[i], last16 && (i == 15), w, w ? ex[k] : 8'h00,
                 10'(k), k == 3);
            if (w) k++;
            if (bub) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 10'd0, 1'b0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", {31'd0, pool_valid_o}, 32'd0);
        chk("rst_last", {31'd0, pool_last_o}, 32'd0);
        chk("rst_data", {24'd0, pool_result_o}, 32'd0);
        chk("rst_addr", {22'd0, pool_result_address_o}, 32'd0);
    endtask

    logic [7:0] fa [16] = '{8'd1, 8'd2, 8'd4, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8,
                            8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    logic [7:0] fb [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                            8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    logic [7:0] fc [16] = '{8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,
                            8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [7:0] fs [16] = '{8'hFB, 8'h01, 8'h00, 8'h00, 8'hF3, 8'h02, 8'h00, 8'h00,
                            8'h80, 8'h7F, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0] ea [4] = '{8'd6, 8'd8, 8'd14, 8'd16};
    logic [7:0] ec [4] = '{8'd16, 8'd14, 8'd8, 8'd6};
`ifdef POOL_SIGNED_EN
    logic [7:0] es [4] = '{8'h02, 8'h00, 8'h7F, 8'h00};
`else
    logic [7:0] es [4] = '{8'hFB, 8'h00, 8'h80, 8'h00};
`endif

    initial begin
        rst                  = 1'b0;
        act_last_i           = 1'b0;
        act_valid_i          = 1'b0;
        act_result_i         = '0;
        act_result_address_i = '0;
        #12;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // frame 1: 6@0, 8@1, 14@2, 16@3 (last on the final window)
        frame16(fa, ea, 1'b0, 1'b0);

        // act_last_i pulse between frames, then frame with act_last_i on pixel 16
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 10'd0, 1'b0);
        frame16(fb, ea, 1'b1, 1'b0);

        // bubble between every pixel
        frame16(fa, ea, 1'b0, 1'b1);

        // reset after 6 pixels (one window already out), then a fresh frame
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(100 + i), 1'b0, i == 5, 8'd105, 10'd0, 1'b0);
        rst = 1'b0;
        #2;
        chk_reset_outputs();
        @(negedge clk);
        rst    = 1'b1;
        hold_d = '0;
        hold_a = '0;
        frame16(fc, ec, 1'b0, 1'b0);

        // sign-sensitive windows
        frame16(fs, es, 1'b0, 1'b0);

        // act_last_i on pixel #3: partial window dropped, counters cleared
        step(1'b1, 8'd50, 1'b0, 1'b0, 8'h00, 10'd0, 1'b0);
        step(1'b1, 8'd60, 1'b0, 1'b0, 8'h00, 10'd0, 1'b0);
        step(1'b1, 8'd70, 1'b1, 1'b0, 8'h00, 10'd0, 1'b0);
        frame16(fa, ea, 1'b0, 1'b0);

        // act_last_i coinciding with the first window-completing pixel
        for (int i = 0; i < 6; i++)
            step(1'b1, fb[i], i == 5, i == 5, 8'd6, 10'd0, 1'b1);
        frame16(fa, ea, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
